// File: rtl/coin_feeder.sv
// Coin-acceptor front end: debounces three coin sensors, converts each accepted
// coin into 5-cent credit units and replays them downstream as coin=5 pulses.

module coin_channel #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic sense,
   output logic evt
);

   typedef enum logic [1:0] {ARMED_LOW, QUAL_HIGH, LATCHED_HIGH, QUAL_LOW} ch_state_t;

   localparam logic [3:0] DBC = 4'(DEBOUNCE_CYCLES);

   ch_state_t  state, state_n;
   logic [3:0] cnt, cnt_n;
   logic       evt_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ARMED_LOW;
         cnt   <= 4'd0;
         evt   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         evt   <= evt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      evt_n   = 1'b0;
      case (state)
         ARMED_LOW: begin
            if (sense) begin
               if (DBC == 4'd1) begin
                  state_n = LATCHED_HIGH;
                  cnt_n   = 4'd0;
                  evt_n   = 1'b1;
               end else begin
                  state_n = QUAL_HIGH;
                  cnt_n   = 4'd1;
               end
            end
         end
         QUAL_HIGH: begin
            if (!sense) begin
               state_n = ARMED_LOW;
               cnt_n   = 4'd0;
            end else if (cnt + 4'd1 == DBC) begin
               state_n = LATCHED_HIGH;
               cnt_n   = 4'd0;
               evt_n   = 1'b1;
            end else begin
               cnt_n = cnt + 4'd1;
            end
         end
         LATCHED_HIGH: begin
            // A held-high sensor stays here: one event per insertion.
            if (!sense) begin
               if (DBC == 4'd1) begin
                  state_n = ARMED_LOW;
                  cnt_n   = 4'd0;
               end else begin
                  state_n = QUAL_LOW;
                  cnt_n   = 4'd1;
               end
            end
         end
         QUAL_LOW: begin
            if (sense) begin
               state_n = LATCHED_HIGH;
               cnt_n   = 4'd0;
            end else if (cnt + 4'd1 == DBC) begin
               state_n = ARMED_LOW;
               cnt_n   = 4'd0;
            end else begin
               cnt_n = cnt + 4'd1;
            end
         end
         default: begin
            state_n = ARMED_LOW;
            cnt_n   = 4'd0;
         end
      endcase
   end

endmodule

module coin_feeder #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int MAX_CREDIT      = 15,
   parameter int PULSE_GAP       = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sense_nickel,
   input  logic       sense_dime,
   input  logic       sense_quarter,
   output logic [4:0] coin,
   output logic       reject,
   output logic [4:0] pending,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, EMIT, GAP} em_state_t;

   localparam logic [2:0] GAP_LAST = (PULSE_GAP > 0) ? 3'(PULSE_GAP - 1) : 3'd0;
   localparam logic [5:0] MAX_C    = 6'(MAX_CREDIT);

   logic [2:0] sense, evt;
   assign sense = {sense_quarter, sense_dime, sense_nickel};

   for (genvar g = 0; g < 3; g++) begin : g_ch
      coin_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
         .clk   (clk),
         .rst   (rst),
         .sense (sense[g]),
         .evt   (evt[g])
      );
   end

   em_state_t  em_state, em_n;
   logic [2:0] gcnt, gcnt_n;
   logic [4:0] units, base, pend_n;
   logic [5:0] sum;
   logic       multi, rej_n;

   always_comb begin
      units = 5'd0;
      case (evt)
         3'b001:  units = 5'd1;
         3'b010:  units = 5'd2;
         3'b100:  units = 5'd5;
         default: units = 5'd0;
      endcase
      multi = (evt[0] & evt[1]) | (evt[0] & evt[2]) | (evt[1] & evt[2]);

      // EMIT is only ever entered with pending>0, so base cannot underflow.
      base   = pending - {4'd0, (em_state == EMIT)};
      sum    = {1'b0, base} + {1'b0, units};
      rej_n  = 1'b0;
      pend_n = base;
      if (evt != 3'b000) begin
         if (multi || sum > MAX_C) rej_n = 1'b1;
         else                      pend_n = sum[4:0];
      end

      em_n   = em_state;
      gcnt_n = gcnt;
      case (em_state)
         IDLE: if (pending != 5'd0) em_n = EMIT;
         EMIT: begin
            if (PULSE_GAP > 0) begin
               em_n   = GAP;
               gcnt_n = 3'd0;
            end else begin
               em_n = (pend_n != 5'd0) ? EMIT : IDLE;
            end
         end
         GAP: begin
            if (gcnt == GAP_LAST) begin
               em_n   = (pending != 5'd0) ? EMIT : IDLE;
               gcnt_n = 3'd0;
            end else begin
               gcnt_n = gcnt + 3'd1;
            end
         end
         default: em_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         em_state <= IDLE;
         gcnt     <= 3'd0;
         coin     <= 5'd0;
         reject   <= 1'b0;
         pending  <= 5'd0;
         busy     <= 1'b0;
      end else begin
         em_state <= em_n;
         gcnt     <= gcnt_n;
         coin     <= (em_n == EMIT) ? 5'd5 : 5'd0;
         reject   <= rej_n;
         pending  <= pend_n;
         busy     <= (pend_n != 5'd0) || (em_n != IDLE);
      end
   end

endmodule

// File: tb/tb_coin_feeder.sv
// Bench for coin_feeder: two configurations driven in lockstep, each checked
// every cycle against a credit/timing model, plus directed literal expectations.

module tb_coin_feeder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] s0 = 3'b000, s1 = 3'b000;  // bit0 nickel, bit1 dime, bit2 quarter
   logic [4:0] c0, c1, p0, p1;
   logic       r0, r1, b0, b1;

   always #5 clk = ~clk;

   coin_feeder #(.DEBOUNCE_CYCLES(4), .MAX_CREDIT(15), .PULSE_GAP(0)) u0 (
      .clk(clk), .rst(rst), .sense_nickel(s0[0]), .sense_dime(s0[1]),
      .sense_quarter(s0[2]), .coin(c0), .reject(r0), .pending(p0), .busy(b0));

   coin_feeder #(.DEBOUNCE_CYCLES(1), .MAX_CREDIT(15), .PULSE_GAP(7)) u1 (
      .clk(clk), .rst(rst), .sense_nickel(s1[0]), .sense_dime(s1[1]),
      .sense_quarter(s1[2]), .coin(c1), .reject(r1), .pending(p1), .busy(b1));

   int dbv[2] = '{4, 1};
   int mxv[2] = '{15, 15};
   int gpv[2] = '{0, 7};
   int uv[3]  = '{1, 2, 5};

   // Model: debounced level per sensor, credit count, pulse/gap timing.
   int m_pend[2], m_gap[2], m_run[2][3];
   bit m_prev[2][3], m_lvl[2][3], m_evt[2][3];
   bit m_coin[2], m_rej[2], m_busy[2];

   int checks = 0, failures = 0;
   int pc[2], rc[2];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic mstep(input int i, input logic [2:0] s, input logic r);
      int nev, units, np;
      bit ncoin, nrej;
      if (r) begin
         m_pend[i] = 0; m_gap[i] = 0; m_coin[i] = 0; m_rej[i] = 0; m_busy[i] = 0;
         for (int c = 0; c < 3; c++) begin
            m_prev[i][c] = 0; m_run[i][c] = 0; m_lvl[i][c] = 0; m_evt[i][c] = 0;
         end
         return;
      end
      nev = 0; units = 0;
      for (int c = 0; c < 3; c++) if (m_evt[i][c]) begin nev++; units += uv[c]; end
      np   = m_pend[i] - (m_coin[i] ? 1 : 0);
      nrej = 0;
      if (nev > 1) nrej = 1;
      else if (nev == 1) begin
         if (np + units > mxv[i]) nrej = 1;
         else np += units;
      end
      ncoin = 0;
      if (m_coin[i]) begin
         if (gpv[i] > 0) m_gap[i] = gpv[i];
         else ncoin = (np > 0);
      end else if (m_gap[i] > 0) begin
         m_gap[i]--;
         if (m_gap[i] == 0) ncoin = (m_pend[i] > 0);
      end else begin
         ncoin = (m_pend[i] > 0);
      end
      for (int c = 0; c < 3; c++) begin
         if (s[c] == m_prev[i][c]) m_run[i][c]++;
         else m_run[i][c] = 1;
         m_prev[i][c] = s[c];
         m_evt[i][c]  = 0;
         if (s[c] != m_lvl[i][c] && m_run[i][c] >= dbv[i]) begin
            m_lvl[i][c] = s[c];
            m_evt[i][c] = s[c];
         end
      end
      m_pend[i] = np;
      m_coin[i] = ncoin;
      m_rej[i]  = nrej;
      m_busy[i] = (np != 0) || ncoin || (m_gap[i] > 0);
   endtask

   task automatic cyc(input logic [2:0] a, input logic [2:0] b, input logic r);
      s0 = a; s1 = b; rst = r;
      @(negedge clk);
      mstep(0, a, r);
      mstep(1, b, r);
      chk("u0.coin", int'(c0), m_coin[0] ? 5 : 0);
      chk("u0.reject", int'(r0), int'(m_rej[0]));
      chk("u0.pending", int'(p0), m_pend[0]);
      chk("u0.busy", int'(b0), int'(m_busy[0]));
      chk("u1.coin", int'(c1), m_coin[1] ? 5 : 0);
      chk("u1.reject", int'(r1), int'(m_rej[1]));
      chk("u1.pending", int'(p1), m_pend[1]);
      chk("u1.busy", int'(b1), int'(m_busy[1]));
      if (c0 == 5'd5) pc[0]++;
      if (c1 == 5'd5) pc[1]++;
      if (r0) rc[0]++;
      if (r1) rc[1]++;
   endtask

   task automatic clr();
      pc[0] = 0; pc[1] = 0; rc[0] = 0; rc[1] = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(3'b000, 3'b000, 1'b0);
   endtask

   logic [2:0] ovf_seq [12] = '{3'b100, 3'b000, 3'b100, 3'b000, 3'b010, 3'b000,
                                3'b001, 3'b000, 3'b100, 3'b000, 3'b010, 3'b000};

   initial begin
      logic [2:0] ra, rb, m;
      cyc(3'b000, 3'b000, 1'b1);
      cyc(3'b000, 3'b000, 1'b1);
      chk("rst.coin", int'(c0), 0);
      chk("rst.pending", int'(p0), 0);
      chk("rst.busy", int'(b1), 0);
      chk("rst.reject", int'(r1), 0);

      // single nickel: event on 4th sample, credit next edge, pulse the edge after
      clr();
      repeat (4) cyc(3'b001, 3'b000, 1'b0);
      cyc(3'b000, 3'b000, 1'b0);
      chk("nickel.pending", int'(p0), 1);
      cyc(3'b000, 3'b000, 1'b0);
      chk("nickel.coin", int'(c0), 5);
      cyc(3'b000, 3'b000, 1'b0);
      chk("nickel.drained", int'(p0), 0);
      idle(5);
      chk("nickel.pulses", pc[0], 1);
      chk("nickel.rejects", rc[0], 0);

      // quarter held 10 cycles: five back-to-back pulses, no re-trigger
      clr();
      for (int k = 1; k <= 10; k++) begin
         cyc(3'b100, 3'b000, 1'b0);
         if (k == 5) chk("quarter.pending5", int'(p0), 5);
         if (k >= 6) chk("quarter.coin", int'(c0), 5);
         if (k == 10) chk("quarter.pending1", int'(p0), 1);
      end
      cyc(3'b000, 3'b000, 1'b0);
      chk("quarter.drained", int'(p0), 0);
      idle(6);
      chk("quarter.pulses", pc[0], 5);

      // dime glitch of 3 samples is filtered
      clr();
      repeat (3) cyc(3'b010, 3'b000, 1'b0);
      idle(8);
      chk("glitch.pulses", pc[0], 0);
      chk("glitch.rejects", rc[0], 0);
      chk("glitch.pending", int'(p0), 0);

      // dime + nickel qualify together -> one reject, nothing credited
      clr();
      repeat (4) cyc(3'b011, 3'b000, 1'b0);
      cyc(3'b000, 3'b000, 1'b0);
      chk("simul.reject", int'(r0), 1);
      idle(6);
      chk("simul.rejects", rc[0], 1);
      chk("simul.pulses", pc[0], 0);
      chk("simul.pending", int'(p0), 0);

      // overflow on the gap=7 / debounce=1 instance
      clr();
      for (int k = 1; k <= 12; k++) begin
         cyc(3'b000, ovf_seq[k-1], 1'b0);
         if (k == 8) chk("ovf.load12", int'(p1), 12);
         if (k == 10) begin
            chk("ovf.reject", int'(r1), 1);
            chk("ovf.unchanged", int'(p1), 12);
         end
         if (k == 12) begin
            chk("ovf.dime_ok", int'(p1), 13);
            chk("ovf.dime_noreject", int'(r1), 0);
         end
      end
      idle(140);
      chk("ovf.pulses", pc[1], 15);
      chk("ovf.rejects", rc[1], 1);

      // reset in the middle of a quarter's emission
      clr();
      repeat (4) cyc(3'b100, 3'b000, 1'b0);
      repeat (3) cyc(3'b000, 3'b000, 1'b0);
      chk("rstmid.pulses_before", pc[0], 2);
      cyc(3'b000, 3'b000, 1'b1);
      chk("rstmid.coin", int'(c0), 0);
      chk("rstmid.pending", int'(p0), 0);
      chk("rstmid.busy", int'(b0), 0);
      clr();
      idle(6);
      chk("rstmid.no_more", pc[0], 0);
      repeat (4) cyc(3'b001, 3'b000, 1'b0);
      idle(6);
      chk("rstmid.nickel_after", pc[0], 1);

      // random sensor activity with occasional resets
      ra = 3'b000; rb = 3'b000;
      for (int n = 0; n < 4000; n++) begin
         m = 3'b000;
         for (int c = 0; c < 3; c++) if ($urandom_range(0, 5) == 0) m[c] = 1'b1;
         ra ^= m;
         m = 3'b000;
         for (int c = 0; c < 3; c++) if ($urandom_range(0, 7) == 0) m[c] = 1'b1;
         rb ^= m;
         cyc(ra, rb, ($urandom_range(0, 499) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
